mac_result_collector: RTL and testbench

- Receiving end of the MAC output stream: consumes f/valid_out from the pipelined MAC (the MAC has no backpressure).
- Keeps only the final accumulator value of each dot-product vector of runtime length vec_len.
- Scales each kept value (arithmetic shift plus saturation), buffers it in a FIFO, and presents it downstream on a valid/ready interface.
- Sits between the MAC datapath and the layer-output writer.

---
 rtl/mac_pkg.sv | 31 +++
 rtl/mac_sync_fifo.sv | 70 +++++++
 rtl/mac_result_collector.sv | 117 +++++++++++
 tb/tb_mac_result_collector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result path: default widths, the scaled result
// type and the saturation helpers used by the scaling blocks.
package mac_pkg;

    localparam int MAC_IN_W  = 28;
    localparam int MAC_OUT_W = 16;

    typedef logic signed [MAC_OUT_W-1:0] res_t;

    localparam logic signed [MAC_IN_W-1:0] SAT_MAX_IN = MAC_IN_W'((64'sd1 <<< (MAC_OUT_W-1)) - 64'sd1);
    localparam logic signed [MAC_IN_W-1:0] SAT_MIN_IN = MAC_IN_W'(-(64'sd1 <<< (MAC_OUT_W-1)));
    localparam res_t RES_MAX = {1'b0, {(MAC_OUT_W-1){1'b1}}};
    localparam res_t RES_MIN = {1'b1, {(MAC_OUT_W-1){1'b0}}};

    function automatic logic sat_hit(input logic signed [MAC_IN_W-1:0] s);
        return (s > SAT_MAX_IN) || (s < SAT_MIN_IN);
    endfunction

    function automatic res_t sat_res(input logic signed [MAC_IN_W-1:0] s);
        res_t r;
        if (s > SAT_MAX_IN) begin
            r = RES_MAX;
        end else if (s < SAT_MIN_IN) begin
            r = RES_MIN;
        end else begin
            r = s[MAC_OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken only when a pop
// frees a slot in the same cycle, otherwise it is ignored and contents stay intact.
module mac_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign empty    = (level_r == {LW{1'b0}});
    assign full     = (level_r == LW'(DEPTH));
    assign level    = level_r;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Head presentation; zero while empty so the output is defined after reset
    always_comb begin
        rd_data = {W{1'b0}};
        if (!empty) begin
            rd_data = mem_r[rd_ptr_r];
        end else begin
            rd_data = {W{1'b0}};
        end
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// Keeps the last MAC accumulator value of each vec_len-long vector, scales it
// (arithmetic shift + saturation) and queues it for a valid/ready consumer.
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int IN_W  = MAC_IN_W,
    parameter int OUT_W = MAC_OUT_W,
    parameter int SHIFT = 8,
    parameter int DEPTH = 8,
    parameter int LEN_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [IN_W-1:0]     f_in,
    input  logic                       f_valid,
    input  logic [LEN_W-1:0]           vec_len,
    input  logic                       clear_cnt,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       sat_flag
);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [LEN_W-1:0]       eff_len_s;
    logic [LEN_W-1:0]       cnt_r;
    logic [LEN_W-1:0]       cnt_next_s;
    logic                   keep_s;
    logic signed [IN_W-1:0] shifted_s;
    logic [OUT_W-1:0]       scaled_s;
    logic                   sat_hit_s;
    logic                   stage_valid_r;
    logic [OUT_W-1:0]       stage_data_r;
    logic                   overflow_r;
    logic                   sat_flag_r;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   pop_s;

    assign shifted_s = f_in >>> SHIFT;
    assign scaled_s  = sat_res(shifted_s);
    assign sat_hit_s = sat_hit(shifted_s);
    assign pop_s     = !fifo_empty_s && out_ready;
    assign out_valid = !fifo_empty_s;
    assign overflow  = overflow_r;
    assign sat_flag  = sat_flag_r;

    // Element counter: ">=" lets a shrunk vec_len close the vector on the next sample
    always_comb begin
        eff_len_s  = (vec_len == LEN_ZERO) ? LEN_ONE : vec_len;
        keep_s     = 1'b0;
        cnt_next_s = cnt_r;
        if (clear_cnt) begin
            if (f_valid) begin
                if (eff_len_s == LEN_ONE) begin
                    keep_s     = 1'b1;
                    cnt_next_s = LEN_ZERO;
                end else begin
                    keep_s     = 1'b0;
                    cnt_next_s = LEN_ONE;
                end
            end else begin
                cnt_next_s = LEN_ZERO;
            end
        end else if (f_valid) begin
            if (cnt_r >= eff_len_s - LEN_ONE) begin
                keep_s     = 1'b1;
                cnt_next_s = LEN_ZERO;
            end else begin
                keep_s     = 1'b0;
                cnt_next_s = cnt_r + LEN_ONE;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter, scaling stage and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r         <= LEN_ZERO;
            stage_valid_r <= 1'b0;
            stage_data_r  <= {OUT_W{1'b0}};
            overflow_r    <= 1'b0;
            sat_flag_r    <= 1'b0;
        end else begin
            cnt_r         <= cnt_next_s;
            stage_valid_r <= keep_s;
            stage_data_r  <= scaled_s;
            if (keep_s && sat_hit_s) begin
                sat_flag_r <= 1'b1;
            end
            if (stage_valid_r && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    mac_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (stage_valid_r),
        .wr_data (stage_data_r),
        .pop     (pop_s),
        .rd_data (out_data),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (level)
    );

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: queue-based reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_mac_result_collector;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [27:0] f_in;
    logic               f_valid;
    logic [15:0]        vec_len;
    logic               clear_cnt;
    logic [15:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         level;
    logic               overflow;
    logic               sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    mac_result_collector dut (
        .clk       (clk),
        .reset     (reset),
        .f_in      (f_in),
        .f_valid   (f_valid),
        .vec_len   (vec_len),
        .clear_cnt (clear_cnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: vector position, one-cycle scaling delay, bounded queue
    logic [15:0] mq[$];
    int          m_cnt;
    bit          m_stage_v;
    logic [15:0] m_stage_d;
    bit          m_ovf;
    bit          m_sat;

    function automatic logic [15:0] scale(input logic [27:0] v, output bit sat);
        longint x;
        longint s;
        x = longint'(v);
        if (v[27]) x = x - (64'sd1 <<< 28);
        s = x >>> 8;
        sat = 1'b0;
        if (s > 64'sd32767) begin
            sat = 1'b1;
            return 16'h7FFF;
        end else if (s < -64'sd32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        return s[15:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        int  eff;
        bit  keep;
        bit  popped;
        bit  sh;
        if (reset) begin
            mq.delete();
            m_cnt = 0; m_stage_v = 1'b0; m_stage_d = 16'h0; m_ovf = 1'b0; m_sat = 1'b0;
        end else begin
            popped = (mq.size() > 0) && out_ready;
            if (popped) void'(mq.pop_front());
            if (m_stage_v) begin
                if (mq.size() < 8) mq.push_back(m_stage_d);
                else m_ovf = 1'b1;
            end
            eff  = (vec_len == 16'd0) ? 1 : int'(vec_len);
            keep = 1'b0;
            if (clear_cnt) begin
                if (f_valid) begin
                    keep  = (eff == 1);
                    m_cnt = (eff == 1) ? 0 : 1;
                end else begin
                    m_cnt = 0;
                end
            end else if (f_valid) begin
                if (m_cnt >= eff - 1) begin
                    keep = 1'b1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            m_stage_v = keep;
            if (keep) begin
                m_stage_d = scale(f_in, sh);
                if (sh) m_sat = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("m_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
            check("m_level", {28'd0, level}, mq.size());
            check("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("m_sat", {31'd0, sat_flag}, {31'd0, m_sat});
            if (mq.size() != 0) check("m_data", {16'd0, out_data}, {16'd0, mq[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [27:0] v, input logic clr);
        f_in = v; f_valid = 1'b1; clear_cnt = clr;
        tick();
    endtask

    task automatic idle(input int n);
        f_valid = 1'b0; clear_cnt = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1; f_in = 28'd0; f_valid = 1'b0; vec_len = 16'd1;
        clear_cnt = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_flags", {30'd0, overflow, sat_flag}, 32'd0);
        reset = 1'b0;
        idle(2);

        // pass-through: output appears exactly two cycles after the sample
        vec_len = 16'd1; out_ready = 1'b1;
        put(28'h0001234, 1'b0);
        check("pt_t1_valid", {31'd0, out_valid}, 32'd0);
        idle(1);
        check("pt_t2_valid", {31'd0, out_valid}, 32'd1);
        check("pt_t2_data", {16'd0, out_data}, 32'h12);
        check("pt_t2_level", {28'd0, level}, 32'd1);
        idle(1);
        check("pt_t3_valid", {31'd0, out_valid}, 32'd0);
        check("pt_t3_level", {28'd0, level}, 32'd0);

        // vector decimation
        vec_len = 16'd4;
        put(28'd1, 1'b0); put(28'd2, 1'b0); put(28'd3, 1'b0); put(28'h0000500, 1'b0);
        idle(1);
        check("dec_data", {16'd0, out_data}, 32'h5);
        check("dec_level", {28'd0, level}, 32'd1);
        idle(3);

        // sign and saturation
        vec_len = 16'd1;
        put(28'hFFFFF00, 1'b0); idle(1);
        check("neg_data", {16'd0, out_data}, 32'hFFFF);
        check("neg_sat", {31'd0, sat_flag}, 32'd0);
        idle(2);
        put(28'h7FFFFFF, 1'b0); idle(1);
        check("pos_sat_data", {16'd0, out_data}, 32'h7FFF);
        check("pos_sat_flag", {31'd0, sat_flag}, 32'd1);
        idle(2);
        put(28'h8000000, 1'b0); idle(1);
        check("neg_sat_data", {16'd0, out_data}, 32'h8000);
        check("neg_sat_flag", {31'd0, sat_flag}, 32'd1);
        idle(2);

        // vec_len shrunk mid-vector closes it on the next sample; 0 acts as 1
        vec_len = 16'd4;
        put(28'h100, 1'b0); put(28'h200, 1'b0);
        vec_len = 16'd2;
        put(28'h300, 1'b0); idle(1);
        check("shrink_data", {16'd0, out_data}, 32'h3);
        idle(2);
        vec_len = 16'd0;
        put(28'h700, 1'b0); idle(1);
        check("len0_data", {16'd0, out_data}, 32'h7);
        idle(2);

        // clear_cnt with a valid sample starts a new vector
        vec_len = 16'd3;
        put(28'h100, 1'b0); put(28'h200, 1'b0); put(28'h300, 1'b1);
        put(28'h400, 1'b0); put(28'h500, 1'b0);
        idle(1);
        check("clr_data", {16'd0, out_data}, 32'h5);
        check("clr_level", {28'd0, level}, 32'd1);
        idle(3);

        // overflow under backpressure, then in-order drain of the survivors
        vec_len = 16'd1; out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) put(28'(i << 8), 1'b0);
        idle(3);
        check("ovf_level", {28'd0, level}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain", {16'd0, out_data}, i);
            tick();
        end
        check("ovf_empty", {28'd0, level}, 32'd0);
        idle(2);

        // asynchronous reset in the middle of a drain
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) put(28'(i << 8), 1'b0);
        idle(2);
        out_ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_level", {28'd0, level}, 32'd0);
        check("arst_flags", {30'd0, overflow, sat_flag}, 32'd0);
        tick();
        reset = 1'b0;
        idle(2);
        check("arst_after", {28'd0, level}, 32'd0);

        // full FIFO: push accepted when a pop happens on the same edge
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) put(28'(i << 8), 1'b0);
        idle(2);
        check("fpp_full", {28'd0, level}, 32'd8);
        put(28'(9 << 8), 1'b0);
        f_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fpp_level", {28'd0, level}, 32'd8);
        check("fpp_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 2; i <= 9; i++) begin
            check("fpp_order", {16'd0, out_data}, i);
            tick();
        end
        check("fpp_empty", {28'd0, level}, 32'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
